// File: rtl/sm_result_collector_pkg.sv
// Shared definitions for the stack-machine result collector.
// Holds the field widths, the err_code constants, the FSM state encoding
// and the saturating counter helper. Optional macro: SM_RES_ERRCNT_EN.
package sm_result_collector_pkg;

    localparam int DATA_W  = 20;
    localparam int PC_W    = 10;
    localparam int ERR_W   = 3;
    localparam int CNT_W   = 10;
    localparam int ENTRY_W = DATA_W + ERR_W + PC_W;

    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    localparam logic [ERR_W-1:0] ERR_NONE  = 3'b000;
    localparam logic [ERR_W-1:0] ERR_FULL  = 3'b001;
    localparam logic [ERR_W-1:0] ERR_UND   = 3'b010;
    localparam logic [ERR_W-1:0] ERR_EMPTY = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/sm_res_fifo.sv
// DEPTH-entry result FIFO with full/empty flags and simultaneous push/pop.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge. The head is presented combinationally from storage and forced to
// zero while the FIFO is empty.
module sm_res_fifo
    import sm_result_collector_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] din_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] dout_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic [AW:0]        count_d;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sm_result_collector.sv
// Stack-machine result collector: queues {data, err, pc} results in a FIFO,
// counts good and error results, flags dropped entries and reports done
// once the program has finished and every entry has been drained.
// Optional macro: SM_RES_ERRCNT_EN enables the per-class error counters.
//
// Downstream handshake: res_valid is high whenever the FIFO holds an entry;
// the head fields are stable while res_valid=1 and res_ready=0; an entry is
// consumed on every rising edge where res_valid=1 and res_ready=1.
module sm_result_collector
    import sm_result_collector_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] out_data,
    input  logic [ERR_W-1:0]  err_code,
    input  logic [PC_W-1:0]   pc,
    input  logic              fin,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [ERR_W-1:0]  res_err,
    output logic [PC_W-1:0]   res_pc,
    output logic [CNT_W-1:0]  n_ok,
    output logic [CNT_W-1:0]  n_err,
    output logic [CNT_W-1:0]  n_full,
    output logic [CNT_W-1:0]  n_und,
    output logic [CNT_W-1:0]  n_empty,
    output logic              overflow,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    state_t             state_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               accepting;
    logic               pop;
    logic               push_req;
    logic               push_ok;
    logic               drop;
    logic [CNT_W-1:0]   n_ok_q;
    logic [CNT_W-1:0]   n_err_q;
    logic               overflow_q;

    // Results are only taken before the program has finished.
    assign accepting = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign pop       = res_ready && !fifo_empty;
    assign push_req  = d_valid && accepting;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;

    sm_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .din_i   ({out_data, err_code, pc}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Program-phase FSM: collect until fin, then drain until the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (d_valid || fin) state_q <= ST_COLLECT;
                ST_COLLECT: if (fin)            state_q <= ST_DRAIN;
                ST_DRAIN:   if (fifo_empty)     state_q <= ST_DONE;
                ST_DONE:    state_q <= ST_DONE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Good/error counters for accepted entries and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_ok_q     <= '0;
            n_err_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                if (err_code == ERR_NONE) begin
                    n_ok_q <= sat_inc(n_ok_q);
                end else begin
                    n_err_q <= sat_inc(n_err_q);
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef SM_RES_ERRCNT_EN
    logic [CNT_W-1:0] n_full_q;
    logic [CNT_W-1:0] n_und_q;
    logic [CNT_W-1:0] n_empty_q;

    // Per-class error counters; codes outside the known set count nowhere here.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_full_q  <= '0;
            n_und_q   <= '0;
            n_empty_q <= '0;
        end else if (push_ok) begin
            case (err_code)
                ERR_FULL:  n_full_q  <= sat_inc(n_full_q);
                ERR_UND:   n_und_q   <= sat_inc(n_und_q);
                ERR_EMPTY: n_empty_q <= sat_inc(n_empty_q);
                default:   ;
            endcase
        end
    end

    assign n_full  = n_full_q;
    assign n_und   = n_und_q;
    assign n_empty = n_empty_q;
`else
    assign n_full  = '0;
    assign n_und   = '0;
    assign n_empty = '0;
`endif

    assign res_valid   = !fifo_empty;
    assign res_data    = fifo_dout[ENTRY_W-1 -: DATA_W];
    assign res_err     = fifo_dout[PC_W +: ERR_W];
    assign res_pc      = fifo_dout[PC_W-1:0];
    assign n_ok        = n_ok_q;
    assign n_err       = n_err_q;
    assign overflow    = overflow_q;
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule
